// File: rtl/alu_ctrl_pipe.sv
// Registered, flow-controlled MIPS ALU control decoder with a multi-cycle MULT/DIV sequencer.
// Optional saturating illegal-op counter enabled by defining ALU_CTRL_ERRCNT_EN.
module alu_ctrl_pipe #(
    parameter int CTRL_W    = 4,
    parameter int FUNCT_W   = 6,
    parameter int MD_CYCLES = 4,
    parameter int ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          alu_op,
    input  logic [FUNCT_W-1:0]  funct,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic                out_err,
    output logic                md_busy
`ifdef ALU_CTRL_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] FUNCT_NOR  = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] FUNCT_MULT = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] FUNCT_DIV  = FUNCT_W'(6'b011010);

    localparam logic [CTRL_W-1:0] CODE_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] CODE_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] CODE_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] CODE_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] CODE_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] CODE_MULT = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] CODE_DIV  = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] CODE_NOR  = CTRL_W'(4'b1100);
    localparam logic [CTRL_W-1:0] CODE_ILL  = CTRL_W'(4'b1110);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              err;
        logic              md;
        logic [CTRL_W-1:0] code;
    } dec_t;

    // Exact-match decode of ALUOp/funct; upper funct bits beyond the MIPS field must be zero.
    function automatic dec_t decode(input logic [1:0] op, input logic [FUNCT_W-1:0] f);
        dec_t d;
        d.err  = 1'b0;
        d.md   = 1'b0;
        d.code = CODE_ADD;
        if (op[1] == 1'b0) begin
            if (op[0] == 1'b1) begin
                d.code = CODE_SUB;
            end else begin
                d.code = CODE_ADD;
            end
        end else begin
            case (f)
                FUNCT_ADD:  d.code = CODE_ADD;
                FUNCT_SUB:  d.code = CODE_SUB;
                FUNCT_AND:  d.code = CODE_AND;
                FUNCT_OR:   d.code = CODE_OR;
                FUNCT_NOR:  d.code = CODE_NOR;
                FUNCT_SLT:  d.code = CODE_SLT;
                FUNCT_MULT: begin
                    d.code = CODE_MULT;
                    d.md   = 1'b1;
                end
                FUNCT_DIV: begin
                    d.code = CODE_DIV;
                    d.md   = 1'b1;
                end
                default: begin
                    d.code = CODE_ILL;
                    d.err  = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] md_code_q, md_code_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic              out_err_q, out_err_d;
    logic              md_busy_q, md_busy_d;

    dec_t dec_s;
    logic in_ready_s;
    logic accept_s;

    // Handshake and decode of the current input word.
    always_comb begin
        dec_s      = decode(alu_op, funct);
        in_ready_s = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state logic for the sequencer and the output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_code_d   = md_code_q;
        out_ctrl_d  = out_ctrl_q;
        out_err_d   = out_err_q;
        md_busy_d   = md_busy_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (dec_s.md && (MD_CYCLES > 1)) begin
                        // Park the code until the multi-cycle op has had its full latency.
                        state_d   = ST_MD_WAIT;
                        cnt_d     = CNT_W'(MD_CYCLES - 1);
                        md_code_d = dec_s.code;
                        md_busy_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_ctrl_d  = dec_s.code;
                        out_err_d   = dec_s.err;
                    end
                end else begin
                    md_busy_d = 1'b0;
                end
            end
            ST_MD_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    // Output register is known to be empty: in_ready gated entry into this state.
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    md_busy_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_ctrl_d  = md_code_q;
                    out_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                md_busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            md_code_q   <= '0;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_err_q   <= 1'b0;
            md_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_code_q   <= md_code_d;
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_err_q   <= out_err_d;
            md_busy_q   <= md_busy_d;
        end
    end

`ifdef ALU_CTRL_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    // Saturating count of accepted words that decoded as illegal.
    always_comb begin
        if (accept_s && dec_s.err && (err_count_q != {ERRCNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Illegal-op counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_err   = out_err_q;
    assign md_busy   = md_busy_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios with literal expectations plus
// randomized traffic against a due-time reference model. Honours ALU_CTRL_ERRCNT_EN.
module tb_alu_ctrl_pipe;
    localparam int CTRL_W   = 4;
    localparam int FUNCT_W  = 6;
    localparam int MDC      = 4;
    localparam int ERRCNT_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  out_ctrl;
    logic               out_err;
    logic               md_busy;
`ifdef ALU_CTRL_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count;
`endif

    alu_ctrl_pipe #(
        .CTRL_W(CTRL_W), .FUNCT_W(FUNCT_W), .MD_CYCLES(MDC), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_err(out_err), .md_busy(md_busy)
`ifdef ALU_CTRL_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: current output word, plus one in-flight MULT/DIV with its due cycle.
    bit         m_valid;
    logic [3:0] m_ctrl;
    bit         m_err;
    bit         m_md;
    longint     m_due;
    logic [3:0] m_mdw;
    int         m_ecnt;
    longint     cyc;

    logic [5:0] legal [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100111, 6'b101010, 6'b011000, 6'b011010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output logic [3:0] c, output bit e, output bit md);
        e  = 1'b0;
        md = 1'b0;
        c  = 4'd2;
        if (!op[1]) begin
            c = op[0] ? 4'd6 : 4'd2;
        end else begin
            case (f)
                6'h20: c = 4'd2;
                6'h22: c = 4'd6;
                6'h24: c = 4'd0;
                6'h25: c = 4'd1;
                6'h27: c = 4'd12;
                6'h2a: c = 4'd7;
                6'h18: begin c = 4'd8; md = 1'b1; end
                6'h1a: begin c = 4'd9; md = 1'b1; end
                default: begin c = 4'd14; e = 1'b1; end
            endcase
        end
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ctrl  = 4'd0;
        m_err   = 1'b0;
        m_md    = 1'b0;
        m_due   = 0;
        m_mdw   = 4'd0;
        m_ecnt  = 0;
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step(input bit r, input bit iv, input logic [1:0] op,
                        input logic [5:0] f, input bit ordy);
        bit         exp_rdy;
        bit         acc;
        bit         nv;
        logic [3:0] c;
        bit         e;
        bit         md;
        rst = r; in_valid = iv; alu_op = op; funct = f; out_ready = ordy;
        #1;
        exp_rdy = !m_md && (!m_valid || ordy);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_ctrl", out_ctrl, m_ctrl);
            chk("out_err", out_err, m_err);
        end
        chk("md_busy", md_busy, m_md);
        chk("in_ready", in_ready, exp_rdy);
`ifdef ALU_CTRL_ERRCNT_EN
        chk("err_count", err_count, m_ecnt);
`endif
        if (r) begin
            model_reset();
        end else begin
            acc = iv && exp_rdy;
            nv  = m_valid && !ordy;
            if (m_md && (m_due == cyc + 1)) begin
                nv = 1'b1; m_ctrl = m_mdw; m_err = 1'b0; m_md = 1'b0;
            end
            if (acc) begin
                ref_decode(op, f, c, e, md);
                if (e && (m_ecnt < (1 << ERRCNT_W) - 1)) m_ecnt++;
                if (md && (MDC > 1)) begin
                    m_md = 1'b1; m_due = cyc + MDC; m_mdw = c;
                end else begin
                    nv = 1'b1; m_ctrl = c; m_err = e;
                end
            end
            m_valid = nv;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state.
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ctrl", out_ctrl, 4'b0000);
        chk("rst_err", out_err, 1'b0);
        chk("rst_busy", md_busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1'b1);

        // Simple R-type add.
        step(0, 1, 2'b10, 6'b100000, 1);
        chk("add_valid", out_valid, 1'b1);
        chk("add_ctrl", out_ctrl, 4'b0010);
        chk("add_err", out_err, 1'b0);

        // Back-to-back slt then nor.
        step(0, 1, 2'b11, 6'b101010, 1);
        chk("slt_ctrl", out_ctrl, 4'b0111);
        chk("b2b_ready", in_ready, 1'b1);
        step(0, 1, 2'b11, 6'b100111, 1);
        chk("nor_ctrl", out_ctrl, 4'b1100);
        chk("nor_valid", out_valid, 1'b1);
        step(0, 0, 2'b00, 6'd0, 1);

        // DIV: busy three cycles, ignored inputs, output after exactly MDC cycles.
        step(0, 1, 2'b10, 6'b011010, 1);
        chk("div_busy1", md_busy, 1'b1);
        chk("div_rdy1", in_ready, 1'b0);
        step(0, 1, 2'b10, 6'b111111, 1);
        chk("div_busy2", md_busy, 1'b1);
        step(0, 1, 2'b10, 6'b111111, 1);
        chk("div_busy3", md_busy, 1'b1);
        chk("div_nov3", out_valid, 1'b0);
        step(0, 1, 2'b10, 6'b111111, 1);
        chk("div_valid", out_valid, 1'b1);
        chk("div_ctrl", out_ctrl, 4'b1001);
        chk("div_busy4", md_busy, 1'b0);
        step(0, 0, 2'b00, 6'd0, 1);

        // Illegal funct.
        step(0, 1, 2'b10, 6'b111111, 1);
        chk("ill_ctrl", out_ctrl, 4'b1110);
        chk("ill_err", out_err, 1'b1);
        step(0, 0, 2'b00, 6'd0, 1);

        // Output hold under backpressure.
        step(0, 1, 2'b01, 6'b000000, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'b00, 6'd0, 0);
            chk("hold_ctrl", out_ctrl, 4'b0110);
            chk("hold_rdy", in_ready, 1'b0);
        end
        step(0, 0, 2'b00, 6'd0, 1);
        chk("drain_valid", out_valid, 1'b0);

        // Reset two cycles after a MULT accept drops the op.
        step(0, 1, 2'b10, 6'b011000, 1);
        step(0, 0, 2'b00, 6'd0, 1);
        step(1, 0, 2'b00, 6'd0, 1);
        chk("mrst_busy", md_busy, 1'b0);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_rdy", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) step(0, 0, 2'b00, 6'd0, 1);

`ifdef ALU_CTRL_ERRCNT_EN
        // Saturation of the illegal-op counter.
        step(1, 0, 2'b00, 6'd0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b10, 6'b110011, 1);
        chk("ecnt_sat", err_count, 2'd3);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] f;
            if ($urandom_range(0, 9) < 7) f = legal[$urandom_range(0, 7)];
            else f = 6'($urandom);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6,
                 2'($urandom), f, $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
